// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply sequencer that owns the shared ALU input mux.
// When idle it passes the pipeline's ALU op straight through; while multiplying it stalls the pipeline.
module alu_mul_sequencer #(
    parameter logic [3:0] ADD_OP     = 4'd0,
    parameter bit         EARLY_TERM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_result,
    input  logic [3:0]  pipe_op,
    input  logic [31:0] pipe_a,
    input  logic [31:0] pipe_b,
    output logic        pipe_stall,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_result_q, resp_result_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            acc_q         <= 32'd0;
            mcand_q       <= 32'd0;
            mplier_q      <= 32'd0;
            cnt_q         <= 6'd0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            cnt_q         <= cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
        end
    end

    // ALU mux and pipeline handshake; kept apart from next-state logic so alu_out never loops back here.
    always_comb begin
        alu_op     = pipe_op;
        alu_a      = pipe_a;
        alu_b      = pipe_b;
        pipe_stall = 1'b0;
        req_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !flush;
            end
            ST_RUN: begin
                alu_op     = ADD_OP;
                alu_a      = acc_q;
                alu_b      = mcand_q;
                pipe_stall = 1'b1;
            end
            ST_DONE: begin
                req_ready = 1'b0;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Next-state and iteration logic; flush overrides every transition.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        cnt_d         = cnt_q;
        resp_valid_d  = 1'b0;
        resp_result_d = resp_result_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    mcand_d  = req_a;
                    mplier_d = req_b;
                    acc_d    = 32'd0;
                    cnt_d    = 6'd0;
                    if (EARLY_TERM && ((req_a == 32'd0) || (req_b == 32'd0))) begin
                        state_d       = ST_DONE;
                        resp_valid_d  = 1'b1;
                        resp_result_d = 32'd0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = alu_out;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[30:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 6'd1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if ((cnt_q == 6'd31) || (EARLY_TERM && (mplier_q[31:1] == 31'd0))) begin
                    // acc_d already includes this cycle's partial product.
                    state_d       = ST_DONE;
                    resp_valid_d  = 1'b1;
                    resp_result_d = acc_d;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A flush in the response cycle suppresses the pulse.
    assign resp_valid  = resp_valid_q && !flush;
    assign resp_result = resp_result_q;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle controller that owns the shared 32-bit ALU's input mux. It executes unsigned/low-word MUL by iterative shift-and-add, issuing ALU ADD operations. When idle, it passes the pipeline's single-cycle ALU op straight through. While a multiply is running, it holds the pipeline's ALU port with a stall. It sits in EX between decode/operand forwarding and the ALU instance.

Parameters:
ADD_OP, 4'd0, ALU op code for ADD; driven on alu_op during multiply iterations.
EARLY_TERM, 1, 1 = finish as soon as the remaining multiplier bits are all zero; 0 = always run 32 iterations.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  multiply request.
req_ready  output  1  request accepted this cycle when req_valid && req_ready.
req_a  input  32  multiplicand.
req_b  input  32  multiplier.
flush  input  1  synchronous abort of any in-flight multiply.
resp_valid  output  1  one-cycle pulse; resp_result valid.
resp_result  output  32  low 32 bits of req_a*req_b.
pipe_op  input  4  pipeline ALU op (pass-through).
pipe_a  input  32  pipeline operand A.
pipe_b  input  32  pipeline operand B.
pipe_stall  output  1  ALU unavailable to the pipeline this cycle.
alu_op  output  4  to ALU op.
alu_a  output  32  to ALU operand_a.
alu_b  output  32  to ALU operand_b.
alu_out  input  32  ALU result (combinational, same cycle).

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: state=IDLE; acc, mcand, mplier, cnt = 0; resp_valid=0; resp_result=0; pipe_stall=0. Outputs are clean on the first cycle after deassertion. Reset mid-run discards the operation with no resp_valid.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - req_ready = !flush.
  - alu_op/alu_a/alu_b = pipe_op/pipe_a/pipe_b (combinational pass-through).
  - pipe_stall = 0.
  - On accept, latch mcand=req_a, mplier=req_b, acc=0, cnt=0.
  - If req_a==0 or req_b==0 (or EARLY_TERM=0 not applicable), go to DONE with acc=0. Otherwise go to RUN.
  - The zero shortcut applies only when EARLY_TERM=1. With EARLY_TERM=0, always go to RUN.
- RUN (one iteration per cycle):
  - alu_op=ADD_OP, alu_a=acc, alu_b=mcand.
  - If mplier[0]: acc<=alu_out (32-bit wrap, carry discarded); else acc unchanged.
  - mcand<=mcand<<1 (zero fill); mplier<=mplier>>1 (zero fill); cnt<=cnt+1 (6-bit).
  - pipe_stall=1; req_ready=0.
  - Exit to DONE when cnt==31, or when EARLY_TERM and mplier[31:1]==0.
- DONE:
  - resp_valid=1, resp_result=acc (registered; resp_result holds last value afterwards).
  - ALU returns to pass-through; pipe_stall=0; req_ready=0.
  - Next state IDLE. No back-to-back accept in DONE.
- Latency (EARLY_TERM=1): accept at cycle 0; RUN lasts (index of highest set bit of req_b)+1 cycles; resp_valid one cycle after the last RUN cycle. Maximum 33 cycles accept-to-resp; zero-operand case is 1 cycle.
- Flush:
  - In RUN or DONE: next state IDLE, resp_valid forced 0 that cycle, result dropped.
  - In IDLE: blocks acceptance.
  - Flush has priority over every other transition.
- req_valid outside IDLE is ignored (not latched). Requesters hold req_valid until req_ready.
- Result equals (req_a*req_b) mod 2^32 for all inputs, including signed interpretation (low word identical).

Test Plan:
1. Pass-through: IDLE, pipe_op=4'd1, pipe_a=10, pipe_b=3 -> alu_op=1, alu_a=10, alu_b=3 same cycle; pipe_stall=0.
2. req_a=3, req_b=5 accepted at cycle 0 -> RUN cycles 1-3, pipe_stall high cycles 1-3, resp_valid at cycle 4 with resp_result=15.
3. req_a=32'hFFFFFFFF, req_b=32'hFFFFFFFF -> 32 RUN cycles, resp_valid at cycle 33, resp_result=32'h00000001.
4. req_a=32'h12345678, req_b=0 -> no RUN; resp_valid at cycle 1, resp_result=0; ALU never driven with ADD_OP.
5. req_a=7, req_b=32'h80000000; assert flush at RUN cycle 10 -> IDLE next cycle, no resp_valid. A subsequent request 6*7 returns 42.
6. rst_n low asynchronously mid-RUN -> all outputs reset immediately. After release, req 2*2 yields resp_result=4 at cycle 3.
